uart_rx_core: RTL and testbench

//  UART receive path; the counterpart of the TX serializer on the same link. Oversamples RX_IN

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sampler.sv | 47 ++++
 rtl/uart_rx_core.sv | 136 +++++++++++++
 tb/tb_uart_rx_core.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the RX and TX paths.
package uart_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // 2-of-3 vote over the three mid-bit captures
    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-period timing for the UART receiver: edge counter, three mid-bit
// captures of the synchronized line and the majority vote over them.
module uart_rx_sampler #(
    parameter int PS_W = 6
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            run,
    input  logic [PS_W-1:0] prescale,
    input  logic            rx_s,
    output logic            sample_bit,
    output logic            bit_end
);
    import uart_pkg::*;

    localparam logic [PS_W-1:0] ONE = {{(PS_W-1){1'b0}}, 1'b1};

    logic [PS_W-1:0] edge_cnt;
    logic [PS_W-1:0] half;
    logic [2:0]      taps;

    assign half       = prescale >> 1;
    assign bit_end    = run && (edge_cnt == prescale - ONE);
    assign sample_bit = majority3(taps);

    // Edge counter: idle at 0, restarts on every bit boundary (which is also
    // where every state change of the frame FSM happens).
    always_ff @(posedge CLK) begin
        if (RST || !run || bit_end) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + ONE;
        end
    end

    // Capture the line at P/2-1, P/2 and P/2+1 of the current bit
    always_ff @(posedge CLK) begin
        if (RST) begin
            taps <= 3'b111;
        end else if (run) begin
            if (edge_cnt == half - ONE) taps[0] <= rx_s;
            if (edge_cnt == half)       taps[1] <= rx_s;
            if (edge_cnt == half + ONE) taps[2] <= rx_s;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive path: synchronizer, frame FSM, LSB-first deserializer,
// optional parity check and stop-bit check with registered result pulses.
module uart_rx_core #(
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH,
    parameter int PS_W       = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PS_W-1:0]       PRESCALE,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);
    import uart_pkg::*;

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    rx_state_t             state, next_state;
    logic                  rx_meta, rx_s;
    logic [PS_W-1:0]       ps_q;
    logic                  par_en_q, par_typ_q;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bad;
    logic                  par_exp;
    logic                  sample_bit, bit_end;

    assign par_exp = (par_typ_q == PAR_EVEN) ? ^shreg : ~(^shreg);

    uart_rx_sampler #(.PS_W(PS_W)) u_sampler (
        .CLK        (CLK),
        .RST        (RST),
        .run        (state != IDLE),
        .prescale   (ps_q),
        .rx_s       (rx_s),
        .sample_bit (sample_bit),
        .bit_end    (bit_end)
    );

    // Two-flop synchronizer for the asynchronous serial line (idles high)
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX_IN;
            rx_s    <= rx_meta;
        end
    end

    // Frame state register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic; every transition out of a bit state waits for bit_end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!rx_s) next_state = START;
            START:   if (bit_end) next_state = sample_bit ? IDLE : DATA;
            DATA:    if (bit_end && bit_cnt == LAST_BIT) next_state = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) next_state = STOP;
            STOP:    if (bit_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Freeze the link configuration for the whole frame at start detection
    always_ff @(posedge CLK) begin
        if (RST) begin
            ps_q      <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
        end else if (state == IDLE && !rx_s) begin
            ps_q      <= PRESCALE;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
        end
    end

    // Deserializer: bits arrive LSB first, so each one enters at the MSB
    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt <= '0;
            shreg   <= '0;
            par_bad <= 1'b0;
        end else if (bit_end) begin
            case (state)
                START: begin
                    bit_cnt <= '0;
                    par_bad <= 1'b0;
                end
                DATA: begin
                    shreg   <= {sample_bit, shreg[DATA_WIDTH-1:1]};
                    bit_cnt <= bit_cnt + CNT_ONE;
                end
                PARITY:  if (sample_bit != par_exp) par_bad <= 1'b1;
                default: ;
            endcase
        end
    end

    // Result registers; pulses last exactly one cycle after the bit's last cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            if (bit_end && state == PARITY && sample_bit != par_exp) begin
                PAR_ERR <= 1'b1;
            end
            if (bit_end && state == STOP) begin
                if (!sample_bit) begin
                    STP_ERR <= 1'b1;
                end else if (!par_bad) begin
                    P_DATA     <= shreg;
                    DATA_VALID <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed frame table, hand-written corner
// sequences and randomized frames checked against a frame-level model.
module tb_uart_rx_core;

    localparam int DW   = 8;
    localparam int PS_W = 6;

    localparam logic [7:0] EV_DV   = 8'd1;
    localparam logic [7:0] EV_PERR = 8'd2;
    localparam logic [7:0] EV_SERR = 8'd3;

    logic            clk = 1'b0;
    logic            RST = 1'b1;
    logic            RX_IN = 1'b1;
    logic            PAR_EN = 1'b0;
    logic            PAR_TYP = 1'b0;
    logic [PS_W-1:0] PRESCALE = 6'd8;
    logic [DW-1:0]   P_DATA;
    logic            DATA_VALID, PAR_ERR, STP_ERR;

    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    // event record: {kind, cycle, data}
    logic [47:0] exp_q[$];
    logic [47:0] obs_q[$];

    uart_rx_core #(.DATA_WIDTH(DW), .PS_W(PS_W)) dut (
        .CLK        (clk),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .PRESCALE   (PRESCALE),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- pulse monitor (sampled mid-cycle) ----------------
    always @(negedge clk) begin
        if (DATA_VALID) obs_q.push_back({EV_DV, cyc, P_DATA});
        if (PAR_ERR)    obs_q.push_back({EV_PERR, cyc, 8'h00});
        if (STP_ERR)    obs_q.push_back({EV_SERR, cyc, 8'h00});
    end

    function automatic logic [47:0] mk_ev(input logic [7:0] kind, input int unsigned t, input logic [7:0] d);
        return {kind, t, d};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    // ---------------- driver ----------------
    // Called at a negedge; k is the first posedge that samples the start bit low.
    task automatic send_frame(input int p, input logic [7:0] d, input logic pe, input logic pb,
                              input logic sb, input bit scramble, input int glitch_at,
                              input int rst_at, output int unsigned k);
        int   nbits;
        logic b;
        nbits = pe ? 11 : 10;
        k = cyc + 1;
        for (int i = 0; i < nbits; i++) begin
            if (i == 0)           b = 1'b0;
            else if (i <= 8)      b = d[i-1];
            else if (pe && i == 9) b = pb;
            else                  b = sb;
            for (int c = 0; c < p; c++) begin
                if (scramble && i == 1 && c == 0) begin
                    PRESCALE = PS_W'(2 * $urandom_range(2, 16));
                    PAR_EN   = 1'($urandom_range(0, 1));
                    PAR_TYP  = 1'($urandom_range(0, 1));
                end
                RX_IN = (i == glitch_at && c == p / 2) ? ~b : b;
                RST   = (i == rst_at && c == p / 2);
                @(negedge clk);
                if (RST) begin
                    chk("rst P_DATA", P_DATA, 0);
                    chk("rst DATA_VALID", DATA_VALID, 0);
                    chk("rst PAR_ERR", PAR_ERR, 0);
                    chk("rst STP_ERR", STP_ERR, 0);
                end
            end
        end
        RX_IN = 1'b1;
        RST   = 1'b0;
    endtask

    task automatic check_events(input string name);
        int n;
        repeat (6) @(negedge clk);
        chk({name, " count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s ev%0d", name, i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    // ---------------- reference model ----------------
    // Frame-level view: a frame ends F*P cycles after its start edge, plus two
    // synchronizer cycles; parity is judged by the count of ones it covers.
    logic [7:0] model_pdata;

    task automatic model_frame(input int unsigned k, input int p, input logic [7:0] d,
                               input logic pe, input logic pt, input logic pb, input logic sb);
        int          ones;
        logic        perr;
        int unsigned t_end;
        ones  = $countones(d) + int'(pb);
        perr  = pe && ((ones % 2) != int'(pt));
        t_end = k + 2 + (pe ? 11 : 10) * p;
        if (perr) exp_q.push_back(mk_ev(EV_PERR, k + 2 + 10 * p, 8'h00));
        if (!sb) begin
            exp_q.push_back(mk_ev(EV_SERR, t_end, 8'h00));
        end else if (!perr) begin
            exp_q.push_back(mk_ev(EV_DV, t_end, d));
            model_pdata = d;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int         p;
        logic       pe;
        logic       pt;
        logic [7:0] d;
        logic       pb;
        logic       sb;
        logic       exp_dv;
        logic       exp_perr;
        logic       exp_serr;
        logic [7:0] exp_pdata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int unsigned k, k1, k2;
        int          p, gap;
        logic [7:0]  d;
        logic        pe, pt, pb, sb;

        vecs[0] = '{8,  1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{8,  1'b1, 1'b1, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
        vecs[2] = '{8,  1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
        vecs[3] = '{8,  1'b0, 1'b0, 8'h66, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h66};
        vecs[4] = '{4,  1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01};
        vecs[5] = '{32, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80};
        vecs[6] = '{8,  1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h80};
        vecs[7] = '{6,  1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF};

        // ---- reset ----
        repeat (3) @(negedge clk);
        chk("reset P_DATA", P_DATA, 0);
        chk("reset DATA_VALID", DATA_VALID, 0);
        chk("reset PAR_ERR", PAR_ERR, 0);
        chk("reset STP_ERR", STP_ERR, 0);
        RST = 1'b0;
        repeat (3) @(negedge clk);

        // ---- table ----
        for (int v = 0; v < 8; v++) begin
            PRESCALE = PS_W'(vecs[v].p);
            PAR_EN   = vecs[v].pe;
            PAR_TYP  = vecs[v].pt;
            repeat (3) @(negedge clk);
            send_frame(vecs[v].p, vecs[v].d, vecs[v].pe, vecs[v].pb, vecs[v].sb, 1'b0, -1, -1, k);
            if (vecs[v].exp_perr) exp_q.push_back(mk_ev(EV_PERR, k + 2 + 10 * vecs[v].p, 8'h00));
            if (vecs[v].exp_dv)
                exp_q.push_back(mk_ev(EV_DV, k + 2 + (vecs[v].pe ? 11 : 10) * vecs[v].p, vecs[v].exp_pdata));
            if (vecs[v].exp_serr)
                exp_q.push_back(mk_ev(EV_SERR, k + 2 + (vecs[v].pe ? 11 : 10) * vecs[v].p, 8'h00));
            check_events($sformatf("vec%0d", v));
            chk($sformatf("vec%0d P_DATA", v), P_DATA, vecs[v].exp_pdata);
        end

        // ---- back-to-back frames, no idle gap ----
        PRESCALE = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) @(negedge clk);
        send_frame(16, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1, k1);
        send_frame(16, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1, k2);
        repeat (6) @(negedge clk);
        chk("b2b count", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            chk("b2b first", obs_q[0], mk_ev(EV_DV, k1 + 162, 8'h3C));
            chk("b2b second kind", obs_q[1][47:40], EV_DV);
            chk("b2b second data", obs_q[1][7:0], 8'hC3);
            // 160 cycles of line time, plus at most the one IDLE cycle that
            // re-arms start detection after the first stop bit
            chk("b2b spacing", (obs_q[1][39:8] - obs_q[0][39:8] >= 160) &&
                               (obs_q[1][39:8] - obs_q[0][39:8] <= 161), 1);
        end
        obs_q.delete();
        chk("b2b P_DATA", P_DATA, 8'hC3);

        // ---- false start: 2 low cycles ----
        PRESCALE = 6'd8;
        repeat (3) @(negedge clk);
        RX_IN = 1'b0;
        repeat (2) @(negedge clk);
        RX_IN = 1'b1;
        repeat (24) @(negedge clk);
        check_events("false start");
        chk("false start P_DATA", P_DATA, 8'hC3);

        // ---- one-cycle glitch in the middle of data bit 3 of 0x00 ----
        send_frame(8, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4, -1, k);
        exp_q.push_back(mk_ev(EV_DV, k + 2 + 80, 8'h00));
        check_events("glitch");
        chk("glitch P_DATA", P_DATA, 8'h00);

        // ---- reset mid-frame at P=32 ----
        PRESCALE = 6'd32;
        repeat (3) @(negedge clk);
        send_frame(32, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1, k);
        exp_q.push_back(mk_ev(EV_DV, k + 2 + 320, 8'h5A));
        check_events("pre-reset");
        send_frame(32, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, -1, 5, k);
        check_events("aborted");
        send_frame(32, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1, k);
        exp_q.push_back(mk_ev(EV_DV, k + 2 + 320, 8'h81));
        check_events("post-reset");
        chk("post-reset P_DATA", P_DATA, 8'h81);

        // ---- randomized frames vs model, config scrambled mid-frame ----
        model_pdata = 8'h81;
        for (int n = 0; n < 40; n++) begin
            p   = 2 * $urandom_range(2, 16);
            pe  = 1'($urandom_range(0, 1));
            pt  = 1'($urandom_range(0, 1));
            d   = 8'($urandom_range(0, 255));
            sb  = ($urandom_range(0, 9) < 8);
            // correct parity bit most of the time, flipped otherwise
            pb  = 1'(($countones(d) + int'(pt)) % 2);
            if ($urandom_range(0, 9) < 2) pb = ~pb;
            gap = $urandom_range(2, 6);
            PRESCALE = PS_W'(p);
            PAR_EN   = pe;
            PAR_TYP  = pt;
            repeat (gap) @(negedge clk);
            send_frame(p, d, pe, pb, sb, 1'b1, -1, -1, k);
            model_frame(k, p, d, pe, pt, pb, sb);
            check_events($sformatf("rand%0d", n));
            chk($sformatf("rand%0d P_DATA", n), P_DATA, model_pdata);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
